// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, assembles
// little-endian 32-bit words, writes them to instruction memory and verifies
// an XOR checksum before releasing the processor from reset.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    // Largest legal word count: the full memory capacity.
    localparam logic [16:0]       LEN_MAX  = 17'd1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [7:0]        chk_q, chk_d;

    logic              accept_s;
    logic [15:0]       len_new_s;
    logic [ADDR_W:0]   wc_inc_s;

    // Outputs are pure decodes of registered state, so reset reaches them at once.
    assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign cpu_rst    = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign word_count = wc_q;

    assign accept_s  = byte_valid && byte_ready;
    assign len_new_s = {byte_data, len_q[7:0]};
    assign wc_inc_s  = wc_q + WC_ONE;

    // Next-state and datapath decisions for the load sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        chk_d   = chk_q;
        if (load_start) begin
            // A start pulse always (re)begins a load; a partial word is dropped.
            state_d = S_LEN;
            idx_d   = 2'd0;
            wc_d    = {(ADDR_W+1){1'b0}};
            addr_d  = {ADDR_W{1'b0}};
            chk_d   = 8'h00;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (accept_s) begin
                        if (idx_q == 2'd0) begin
                            len_d[7:0] = byte_data;
                            idx_d      = 2'd1;
                        end else begin
                            len_d[15:8] = byte_data;
                            idx_d       = 2'd0;
                            if ({1'b0, len_new_s} > LEN_MAX) begin
                                state_d = S_ERR;
                            end else if (len_new_s == 16'd0) begin
                                state_d = S_CHK;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                    end else begin
                        state_d = S_LEN;
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        word_d[{idx_q, 3'b000} +: 8] = byte_data;
                        chk_d = chk_q ^ byte_data;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_WRITE: begin
                    wc_d = wc_inc_s;
                    // Saturate so a full-capacity load never wraps back to word 0.
                    if (addr_q != ADDR_MAX) begin
                        addr_d = addr_q + ADDR_ONE;
                    end else begin
                        addr_d = addr_q;
                    end
                    if (17'(wc_inc_s) == {1'b0, len_q}) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CHK: begin
                    if (accept_s) begin
                        if (byte_data == chk_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        state_d = S_CHK;
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            len_q   <= 16'd0;
            word_q  <= 32'd0;
            addr_q  <= {ADDR_W{1'b0}};
            wc_q    <= {(ADDR_W+1){1'b0}};
            chk_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            chk_q   <= chk_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the
// stimulus and consumed by an independent write monitor.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         total;
    int         bad;
    int         wr_cnt;

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, imem_addr}, {24'd0, e.a});
                check("wr_data", imem_wdata, e.d);
            end
        end
    end

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  t;
        bit  sent;
        t    = 0;
        sent = 1'b0;
        while (!sent && t < 100) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                if (byte_ready) sent = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        byte_valid = 1'b0;
        if (!sent) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: got no ready for byte %h expected ready within 100 cycles", b);
        end
    endtask

    task automatic send_all(input bit gaps);
        while (stim_q.size() > 0) send_byte(stim_q.pop_front(), gaps);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c, input logic [8:0] wc);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, c});
        check({tag, "_wcount"}, {23'd0, word_count}, {23'd0, wc});
        check({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int         w0;
        logic [7:0] cks;
        logic [7:0] b0;
        total      = 0;
        bad        = 0;
        wr_cnt     = 0;
        rst        = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 9'd0);
        @(negedge clk);
        rst = 1'b0;

        // One-word load with good checksum.
        start_load();
        check("s1_len_ready", {31'd0, byte_ready}, 32'd1);
        check("s1_len_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        push_wr(8'd0, 32'h00500093);
        stim_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        send_all(1'b0);
        check_status("s1", 1'b1, 1'b0, 1'b0, 9'd1);
        check("s1_ready", {31'd0, byte_ready}, 32'd0);

        // Two-word load.
        start_load();
        push_wr(8'd0, 32'h00500093);
        push_wr(8'd1, 32'h00700113);
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h70, 8'h00, 8'hA1};
        send_all(1'b0);
        check_status("s2", 1'b1, 1'b0, 1'b0, 9'd2);

        // Bad checksum.
        start_load();
        w0 = wr_cnt;
        push_wr(8'd0, 32'h00500093);
        stim_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC4};
        send_all(1'b0);
        check_status("s3", 1'b0, 1'b1, 1'b1, 9'd1);
        check("s3_writes", wr_cnt - w0, 32'd1);

        // Oversized length goes to error straight after the second length byte.
        start_load();
        w0 = wr_cnt;
        stim_q = '{8'h01, 8'h01};
        send_all(1'b0);
        check_status("s4a", 1'b0, 1'b1, 1'b1, 9'd0);
        check("s4a_ready", {31'd0, byte_ready}, 32'd0);
        check("s4a_writes", wr_cnt - w0, 32'd0);

        // Zero-length load.
        start_load();
        stim_q = '{8'h00, 8'h00, 8'h00};
        send_all(1'b0);
        check_status("s4b", 1'b1, 1'b0, 1'b0, 9'd0);

        // Two-word load with random valid gaps.
        start_load();
        push_wr(8'd0, 32'h00500093);
        push_wr(8'd1, 32'h00700113);
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h70, 8'h00, 8'hA1};
        send_all(1'b1);
        check_status("s5", 1'b1, 1'b0, 1'b0, 9'd2);

        // Reset in the middle of a word.
        start_load();
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00};
        send_all(1'b0);
        rst = 1'b1;
        #1;
        check("s5r_ready", {31'd0, byte_ready}, 32'd0);
        check("s5r_we", {31'd0, imem_we}, 32'd0);
        check("s5r_addr", {24'd0, imem_addr}, 32'd0);
        check("s5r_wdata", imem_wdata, 32'd0);
        check_status("s5r", 1'b0, 1'b0, 1'b1, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        start_load();
        push_wr(8'd0, 32'h00500093);
        stim_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        send_all(1'b0);
        check_status("s5post", 1'b1, 1'b0, 1'b0, 9'd1);

        // Restart after three data bytes: the partial word must not be written.
        start_load();
        w0 = wr_cnt;
        stim_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50};
        send_all(1'b0);
        start_load();
        check("s6_restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        push_wr(8'd0, 32'h00500093);
        stim_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        send_all(1'b0);
        check_status("s6", 1'b1, 1'b0, 1'b0, 9'd1);
        check("s6_writes", wr_cnt - w0, 32'd1);

        // Full-capacity load: 256 words, last one at address 255.
        start_load();
        stim_q = '{8'h00, 8'h01};
        cks = 8'h00;
        for (int i = 0; i < 256; i++) begin
            b0 = 8'(i);
            stim_q.push_back(b0);
            stim_q.push_back(8'h5A);
            stim_q.push_back(~b0);
            stim_q.push_back(8'h01);
            cks = cks ^ b0 ^ 8'h5A ^ ~b0 ^ 8'h01;
            push_wr(b0, {8'h01, ~b0, 8'h5A, b0});
        end
        stim_q.push_back(cks);
        send_all(1'b0);
        check_status("full", 1'b1, 1'b0, 1'b0, 9'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, as the instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-004 The block SHALL have port load_start, input, 1, a one-cycle pulse that begins or restarts a program load.
REQ-005 The block SHALL have port byte_valid, input, 1, meaning the source offers byte_data.
REQ-006 The block SHALL have port byte_data, input, 8, the stream byte.
REQ-007 The block SHALL have port byte_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 The block SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, ADDR_W, the word address.
REQ-010 The block SHALL have port imem_wdata, output, 32, the instruction word.
REQ-011 The block SHALL have port cpu_rst, output, 1, holding the processor in reset.
REQ-012 The block SHALL have port done, output, 1, meaning the load completed with a good checksum.
REQ-013 The block SHALL have port error, output, 1, meaning the load failed (length or checksum).
REQ-014 The block SHALL have port word_count, output, ADDR_W+1, the number of words written in the current load.

Function
REQ-015 Stream format SHALL be: 2 length bytes N (little-endian, 16 bit), then 4*N instruction bytes (little-endian per word), then 1 checksum byte.
REQ-016 A byte SHALL transfer only on a cycle with byte_valid && byte_ready; byte_data is ignored otherwise.
REQ-017 States SHALL be IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
REQ-018 byte_ready SHALL be high only in LEN, DATA and CHK.
REQ-019 IDLE, DONE or ERR plus load_start SHALL go to LEN and clear the byte index, word_count, address, checksum accumulator, done and error.
REQ-020 LEN SHALL accept 2 bytes, then go to ERR if N > 2^ADDR_W, to CHK if N = 0, else to DATA.
REQ-021 DATA SHALL shift each accepted byte into bits [8k+7:8k] of the word for byte k = 0..3; the 4th byte SHALL go to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr = current address and imem_wdata = the assembled word. Afterwards address and word_count increment. If word_count then equals N, go to CHK; else return to DATA.
REQ-023 The checksum accumulator SHALL be the XOR of all instruction bytes; length bytes are excluded.
REQ-024 CHK SHALL accept one byte: equal to the accumulator -> DONE; different -> ERR.
REQ-025 imem_we SHALL be 0 in every state except WRITE.
REQ-026 cpu_rst SHALL be 1 in every state except DONE; it falls on the cycle DONE is entered.
REQ-027 done SHALL equal 1 only in DONE; error SHALL equal 1 only in ERR; both hold until the next load_start or reset.
REQ-028 load_start in LEN, DATA, WRITE or CHK SHALL abort and restart at LEN. Memory words already written stay, cpu_rst stays 1, and no partial word is written.
REQ-029 Address SHALL NOT wrap: N = 2^ADDR_W is legal and writes the last word at address 2^ADDR_W-1.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and set byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, word_count=0, regardless of the operation in progress.

Verification
REQ-031 Scenario 1: load_start; bytes 01 00 93 00 50 00 C3 -> one imem_we pulse at addr 0 with data 0x00500093, then done=1, cpu_rst=0, word_count=1.
REQ-032 Scenario 2: bytes 02 00 93 00 50 00 13 01 70 00 A1 -> writes 0x00500093 at addr 0 and 0x00700113 at addr 1, then done=1.
REQ-033 Scenario 3: same as scenario 1 but checksum byte C4 -> error=1, done=0, cpu_rst=1, one write performed.
REQ-034 Scenario 4: length bytes 01 01 (257) with ADDR_W=8 -> ERR right after the 2nd byte, no imem_we; length 00 00 followed by checksum 00 -> done=1, word_count=0.
REQ-035 Scenario 5: byte_valid toggled randomly during scenario 2 -> identical writes; rst pulsed after 2 data bytes -> outputs at reset values the same cycle, and a following full load succeeds.
REQ-036 Scenario 6: load_start after 3 data bytes of a load -> restart with no write of the partial word; the subsequent scenario 1 stream loads correctly.
